// File: rtl/block_pipe_decode_if.sv
// Stream interface for block_pipe_decode: upstream valid/ready/data,
// downstream valid/ready/data, plus the stage-2 busy indicator.
// master = side that feeds words in and consumes results (the environment),
// slave  = the decoder itself.
interface block_pipe_decode_if #(
    parameter int DATA_W = 32
);
    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic              ready_o;
    logic              ready_i;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic              busy_o;

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, busy_o
    );

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, busy_o
    );
endinterface

// File: rtl/block_pipe_decode.sv
// block_pipe_decode: three-stage valid/ready pipeline that undoes the forward
// "add ADD_K, multiply by MUL_K" pipe: x = y * INV_K - ADD_K (mod 2^DATA_W).
//   stage 1: input register
//   stage 2: multiply by INV_K (serial shift-add, DATA_W iterations)
//   stage 3: subtract ADD_K, drives the output
// Optional macro BLOCK_PIPE_DECODE_FAST_MUL_EN: stage 2 uses a single-cycle
// combinational multiply instead (done one edge after load). Results are
// identical in both builds; only latency and throughput differ.
module block_pipe_decode #(
    parameter int              DATA_W = 32,
    parameter logic [DATA_W-1:0] ADD_K  = 4,
    parameter logic [DATA_W-1:0] INV_K  = 32'hCCCCCCCD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    block_pipe_decode_if.slave   bus
);

    // ---------------- stage registers ----------------
    logic              valid1;
    logic [DATA_W-1:0] data1;

    logic              valid2;
    logic [DATA_W-1:0] acc;
`ifdef BLOCK_PIPE_DECODE_FAST_MUL_EN
    logic              cnt;      // 0 on the load edge, 1 once the product is in acc
`else
    localparam int CNT_W = $clog2(DATA_W + 1);
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [CNT_W-1:0]  cnt;
`endif

    logic              valid3;
    logic [DATA_W-1:0] data3;

    // ---------------- handshake network ----------------
    logic done2;
    logic ready1;
    logic ready2;
    logic ready3;
    logic load1;
    logic load2;
    logic load3;

    // Ready chain runs back from ready_i through the done flags; valid_i only
    // feeds the load enables, never ready_o.
    always_comb begin
`ifdef BLOCK_PIPE_DECODE_FAST_MUL_EN
        done2  = cnt;
`else
        done2  = (cnt == CNT_W'(DATA_W));
`endif
        ready3 = !valid3 || bus.ready_i;
        ready2 = !valid2 || (done2 && ready3);
        ready1 = !valid1 || ready2;
        load1  = bus.valid_i && ready1;
        load2  = valid1 && ready2;
        load3  = valid2 && done2 && ready3;
    end

    // Stage 1: plain register of the incoming encoded word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1 <= 1'b0;
            data1  <= '0;
        end else begin
            if (ready1) valid1 <= bus.valid_i;
            if (load1)  data1  <= bus.data_i;
        end
    end

`ifdef BLOCK_PIPE_DECODE_FAST_MUL_EN
    // Stage 2 (fast): whole truncated product captured on the load edge,
    // done flag set one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid2 <= 1'b0;
            acc    <= '0;
            cnt    <= 1'b0;
        end else begin
            if (ready2) valid2 <= valid1;
            if (load2) begin
                acc <= data1 * INV_K;
                cnt <= 1'b0;
            end else if (valid2 && !done2) begin
                cnt <= 1'b1;
            end
        end
    end
`else
    // Stage 2 (serial): one shift-add step per edge, LSB of the multiplier
    // first. A load replaces all state, so a new word can enter on the same
    // edge the finished one leaves. State freezes while done and stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid2 <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            if (ready2) valid2 <= valid1;
            if (load2) begin
                acc    <= '0;
                mcand  <= data1;
                mplier <= INV_K;
                cnt    <= '0;
            end else if (valid2 && !done2) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end
`endif

    // Stage 3: remove the additive constant (wraps modulo 2^DATA_W).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid3 <= 1'b0;
            data3  <= '0;
        end else begin
            if (ready3) valid3 <= valid2 && done2;
            if (load3)  data3  <= acc - ADD_K;
        end
    end

    assign bus.ready_o = ready1;
    assign bus.valid_o = valid3;
    assign bus.data_o  = data3;
    assign bus.busy_o  = valid2 && !done2;

endmodule

// File: doc/block_pipe_decode.md
Name: block_pipe_decode

Overview:
- Three-stage valid/ready pipeline; inverse of the forward "add ADD_K then multiply by MUL_K" block pipe.
- Recovers the original word: x = y * INV_K − ADD_K (mod 2^DATA_W), where INV_K is the modular inverse of MUL_K.
- Sits at the receive end of a stream produced by the forward pipe.
- Stage 2 is a multi-cycle serial shift-add multiplier, so back-pressure propagates through a stage that is not always done.

Parameters:
- DATA_W, 32, data width.
- ADD_K, 4, additive constant removed in stage 3.
- INV_K, 32'hCCCCCCCD, modular inverse of MUL_K=5 mod 2^DATA_W. MUL_K*INV_K mod 2^DATA_W must be 1; not checked in RTL.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  upstream data valid
- data_i  in  DATA_W  encoded word y
- ready_o  out  1  upstream ready (stage-1 ready)
- ready_i  in  1  downstream ready
- valid_o  out  1  decoded word valid
- data_o  out  DATA_W  decoded word x
- busy_o  out  1  stage 2 holds an unfinished multiply

Behaviour:
- Reset: all valids 0, all data/accumulator/counter registers 0; ready_o=1, valid_o=0, data_o=0, busy_o=0. Reset mid-multiply discards every in-flight word.
- Per stage n: ready_n = !valid_n || (done_n && ready_{n+1}).
  - valid_n loads from upstream valid&done when ready_n.
  - Data loads only when upstream valid&done && ready_n.
  - Handshake on any interface = valid && ready on the same rising edge.
- Stage 1: done=1; registers data_i.
- Stage 2 load (stage-1 word transfers in):
  - acc=0, mcand=stage-1 data, mplier=INV_K, cnt=0.
- Stage 2 iteration (each later edge while valid2 && cnt<DATA_W):
  - If mplier[0]: acc += mcand (mod 2^DATA_W).
  - mcand <<= 1; mplier >>= 1; cnt += 1.
  - cnt width is clog2(DATA_W+1).
- Stage 2 completion:
  - done2 = (cnt==DATA_W). busy_o = valid2 && !done2.
  - acc, mcand, mplier and cnt are frozen while done2 && !ready3.
  - A new load in the same edge as the transfer out replaces all stage-2 state; no bubble.
- Stage 3: done=1; loads acc − ADD_K (mod 2^DATA_W, wrap allowed). data_o=stage-3 data, valid_o=valid3.
- Latency, no back-pressure: valid_o rises DATA_W+2 edges after the input handshake edge (34 at default).
- Throughput: one word per DATA_W+1 cycles.
- Stall: ready_i=0 holds valid_o and data_o stable. Stage 2 then finishes and holds; ready_o falls once stages 1–3 are all full.
- ready_o is combinational from ready_i through done flags. No combinational path from valid_i to ready_o.
- Not a skid buffer: valid_i with ready_o=0 is ignored; upstream must hold.

Optional Feature:
- Macro: BLOCK_PIPE_DECODE_FAST_MUL_EN.
- Defined:
  - Stage 2 loads acc = stage-1 data * INV_K (combinational multiply, truncated) on the load edge.
  - done2 asserts one edge after load; cnt is a 1-bit flag; latency 3 edges; throughput one word per 2 cycles.
- Undefined: serial multiplier as above.
- Data results are identical in both modes.

Test Plan:
- Reset, then data_i=55 (=(7+4)*5) with ready_i=1 → data_o=7, valid_o rises 34 edges after the handshake; busy_o high for 32 cycles.
- data_i=0 → data_o=32'hFFFFFFFC. data_i=15 (forward of 32'hFFFFFFFF) → data_o=32'hFFFFFFFF (wrap check).
- Back-to-back stream: 55, 60, 65, ready_i=1 → outputs 7, 8, 9 in order, spaced 33 cycles apart; ready_o low while stage 2 is busy and stage 1 is full.
- Stall: hold ready_i=0 for 100 cycles after the first output → data_o held at 7; ready_o low once three words are in flight; releasing ready_i drains 8 and 9 with no loss or duplication.
- Assert rst_n=0 at cycle 10 of a multiply → valid_o=0, busy_o=0, ready_o=1 next edge; a following input of 55 produces 7.
- With BLOCK_PIPE_DECODE_FAST_MUL_EN, repeat the first three scenarios → same data values, latency 3, output spacing 2 cycles.
